muldiv_unit: RTL and testbench

Iterative multiply/divide responder for the MIPS pipeline's execute stage, serving `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. The execute stage issues a request with `start`. The unit accepts it, computes over WIDTH+2 cycles while holding `busy`, then writes its internal HI/LO registers and pulses `done`. The hazard unit stalls on `busy`; `mfhi`/`mflo` read `hi`/`lo` directly.

---
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for a MIPS execute stage.
// Radix-2 shift-add multiply, restoring shift-subtract divide, sign fix-up in one final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   b_q, rem_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               done_q;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // acc_q low half starts as |src_a|: multiplier bits shift out of it for a
  // multiply, dividend bits shift out and quotient bits shift in for a divide.
  // Divide-by-zero and the signed overflow case fall out of the datapath
  // naturally (quotient all ones, remainder = dividend; 2^(W-1) negated stays 2^(W-1)).
  always_comb begin
    a_mag     = (!op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag     = (!op[0] && src_b[WIDTH-1]) ? -src_b : src_b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = (is_signed && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quo_fix   = (is_signed && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = (is_signed && sign_a_q) ? -rem_q : rem_q;
  end

  // NOTE: every register here uses non-blocking assignment so all updates
  // see the pre-edge values of the others, matching flip-flop behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= ~op[0] & src_a[WIDTH-1];
            sign_b_q <= ~op[0] & src_b[WIDTH-1];
            b_q      <= b_mag;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            rem_q    <= '0;
            count_q  <= CW'(WIDTH);
            state_q  <= CALC;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        CALC: begin
          count_q <= count_q - CW'(1);
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              rem_q             <= div_diff[WIDTH-1:0];
              acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q             <= div_shift[WIDTH-1:0];
              acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (count_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand-written control sequences,
// results checked through an expected-value queue popped on each done pulse.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         hi_we, lo_we;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t exp_q[$];
  vec_t vecs[13];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the request.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_q.push_back('{op: o, a: a, b: b, hi: ehi, lo: elo});
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Waits for done, then pops the scoreboard and compares HI/LO.
  task automatic wait_done(input string tag, output int lat, output bit busy_ok);
    vec_t e;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_scoreboard: got done with empty queue expected pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    int  seen;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
    vecs[6]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[8]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[9]  = '{2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    vecs[10] = '{2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[11] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[12] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      wait_done($sformatf("vec%0d", i), lat, busy_ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_busy_held", i), {31'b0, busy_ok}, 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // start pulsed mid-CALC with other operands must be ignored
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart", lat, busy_ok);
    check("midstart_latency", 32'(lat), 32'(LAT - 11));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("midstart_no_second_op", 32'(seen), 32'd0);

    // back-to-back: new start in the done cycle
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("b2b_first", lat, busy_ok);
    issue(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    check("b2b_busy_rise", {31'b0, busy}, 32'd1);
    check("b2b_done_fall", {31'b0, done}, 32'd0);
    wait_done("b2b_second", lat, busy_ok);
    check("b2b_latency", 32'(lat), 32'(LAT));
    @(negedge clk);

    // move-to writes ignored while busy, HI/LO hold during CALC
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    repeat (5) @(negedge clk);
    check("calc_hold_hi", hi, 32'hFFFFFFFF);
    check("calc_hold_lo", lo, 32'hFFFFFFF1);
    hi_we = 1'b1; wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    hi_we = 1'b0;
    wait_done("mthi_busy", lat, busy_ok);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle_hi", hi, 32'h12345678);
    check("mthi_idle_lo", lo, 32'd12);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", hi, 32'hA5A5A5A5);
    check("mtboth_lo", lo, 32'hA5A5A5A5);

    // move-to in the same cycle as start is dropped
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    issue(2'b01, 32'd2, 32'd2, 32'd0, 32'd4);
    hi_we = 1'b0;
    check("mt_with_start_hi", hi, 32'hA5A5A5A5);
    wait_done("mt_with_start", lat, busy_ok);
    @(negedge clk);

    // asynchronous reset mid-CALC
    hi_we = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    hi_we = 1'b0;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_done("post_rst", lat, busy_ok);
    check("post_rst_latency", 32'(lat), 32'(LAT));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
